// File: rtl/cpu_issue_unit_pkg.sv
// Shared definitions for the issue unit: opcode map (also used by the ALU),
// instruction field positions, sequencer state encoding and small helpers.
package cpu_issue_unit_pkg;

    // Opcode map, IR[15:12]
    localparam logic [3:0] OpAdd    = 4'h0;
    localparam logic [3:0] OpSub    = 4'h1;
    localparam logic [3:0] OpAnd    = 4'h2;
    localparam logic [3:0] OpOr     = 4'h3;
    localparam logic [3:0] OpShift  = 4'h4;
    localparam logic [3:0] OpMove   = 4'h5;
    localparam logic [3:0] OpLoadc  = 4'h6;
    localparam logic [3:0] OpJump   = 4'h7;
    localparam logic [3:0] OpLoad   = 4'h8;
    localparam logic [3:0] OpStore  = 4'h9;
    localparam logic [3:0] OpUndef1 = 4'hA;
    localparam logic [3:0] OpUndef2 = 4'hB;
    localparam logic [3:0] OpUndef3 = 4'hC;
    localparam logic [3:0] OpUndef4 = 4'hD;
    localparam logic [3:0] OpUndef5 = 4'hE;
    localparam logic [3:0] OpUndef6 = 4'hF;

    // Instruction field bit positions
    localparam int unsigned OpcMsb   = 15;
    localparam int unsigned OpcLsb   = 12;
    localparam int unsigned ExtraMsb = 11;
    localparam int unsigned ExtraLsb = 10;
    localparam int unsigned RaMsb    = 9;
    localparam int unsigned RaLsb    = 8;
    localparam int unsigned RbMsb    = 7;
    localparam int unsigned RbLsb    = 6;
    localparam int unsigned ConstMsb = 7;
    localparam int unsigned ConstLsb = 0;

    // Sequencer states
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StMem,
        StHalt
    } state_e;

    // Sign-extend an 8-bit branch offset to 16 bits
    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/cpu_issue_unit_regfile.sv
// 4x16 register file: two combinational read ports, one synchronous write port,
// asynchronous active-low clear of every entry.
module cpu_issue_unit_regfile #(
    parameter int unsigned NumRegs = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  raddr_a_i,
    output logic [15:0] rdata_a_o,
    input  logic [1:0]  raddr_b_i,
    output logic [15:0] rdata_b_o,
    input  logic        we_i,
    input  logic [1:0]  waddr_i,
    input  logic [15:0] wdata_i
);

    logic [15:0] regs_q [NumRegs];

    // Register storage with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read ports
    always_comb begin
        rdata_a_o = regs_q[raddr_a_i];
        rdata_b_o = regs_q[raddr_b_i];
    end

endmodule

// File: rtl/cpu_issue_unit.sv
// Fetch/decode/register-file/writeback sequencer feeding the ALU.
// Optional feature macro: CPU_ISSUE_RETIRE_CNT_EN adds the o_retired counter.
module cpu_issue_unit
    import cpu_issue_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned NUM_REGS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [15:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [15:0] i_imem_data,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [15:0] o_dmem_addr,
    output logic [15:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [15:0] i_dmem_rdata,
    output logic [3:0]  o_alu_opcode,
    output logic [1:0]  o_alu_extra,
    output logic [15:0] o_alu_data1,
    output logic [15:0] o_alu_data2,
    output logic [7:0]  o_alu_const,
    input  logic [15:0] i_alu_data,
    output logic [15:0] o_pc,
    output logic        o_halted
`ifdef CPU_ISSUE_RETIRE_CNT_EN
    ,
    output logic [31:0] o_retired
`endif
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;

    logic [3:0]  opc;
    logic [1:0]  extra;
    logic [1:0]  ra;
    logic [1:0]  rb;
    logic [7:0]  cnst;
    logic [15:0] ra_data;
    logic [15:0] rb_data;
    logic        rf_we;
    logic [15:0] rf_wdata;
    logic [15:0] pc_inc;
    logic [15:0] pc_rel;

    assign opc    = ir_q[OpcMsb:OpcLsb];
    assign extra  = ir_q[ExtraMsb:ExtraLsb];
    assign ra     = ir_q[RaMsb:RaLsb];
    assign rb     = ir_q[RbMsb:RbLsb];
    assign cnst   = ir_q[ConstMsb:ConstLsb];
    assign pc_inc = pc_q + 16'd1;
    assign pc_rel = pc_q + sext8(cnst);
    assign o_pc   = pc_q;

    cpu_issue_unit_regfile #(
        .NumRegs (NUM_REGS)
    ) u_regfile (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .raddr_a_i (ra),
        .rdata_a_o (ra_data),
        .raddr_b_i (rb),
        .rdata_b_o (rb_data),
        .we_i      (rf_we),
        .waddr_i   (ra),
        .wdata_i   (rf_wdata)
    );

    // Sequencer state, PC and instruction register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, writeback and all bus/ALU outputs; everything idles at 0
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        rf_we        = 1'b0;
        rf_wdata     = 16'h0000;
        o_imem_req   = 1'b0;
        o_imem_addr  = 16'h0000;
        o_dmem_req   = 1'b0;
        o_dmem_we    = 1'b0;
        o_dmem_addr  = 16'h0000;
        o_dmem_wdata = 16'h0000;
        o_alu_opcode = 4'h0;
        o_alu_extra  = 2'b00;
        o_alu_data1  = 16'h0000;
        o_alu_data2  = 16'h0000;
        o_alu_const  = 8'h00;
        o_halted     = 1'b0;

        case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                o_imem_req  = 1'b1;
                o_imem_addr = pc_q;
                if (i_imem_ack) begin
                    ir_d    = i_imem_data;
                    state_d = StExec;
                end
            end
            StExec: begin
                o_alu_opcode = opc;
                o_alu_extra  = extra;
                o_alu_const  = cnst;
                case (opc)
                    OpAdd, OpSub, OpAnd, OpOr, OpShift: begin
                        o_alu_data1 = ra_data;
                        o_alu_data2 = rb_data;
                        rf_we       = 1'b1;
                        rf_wdata    = i_alu_data;
                        pc_d        = pc_inc;
                        state_d     = StFetch;
                    end
                    OpMove: begin
                        o_alu_data1 = rb_data;
                        rf_we       = 1'b1;
                        rf_wdata    = i_alu_data;
                        pc_d        = pc_inc;
                        state_d     = StFetch;
                    end
                    OpLoadc: begin
                        rf_we    = 1'b1;
                        // extra[0] selects the high byte, keeping the low byte
                        rf_wdata = extra[0] ? {cnst, ra_data[7:0]} : {8'h00, cnst};
                        pc_d     = pc_inc;
                        state_d  = StFetch;
                    end
                    OpJump: begin
                        state_d = StFetch;
                        case (extra)
                            2'd0:    pc_d = rb_data;
                            2'd1:    pc_d = pc_rel;
                            2'd2:    pc_d = (ra_data == 16'h0000) ? pc_rel : pc_inc;
                            default: state_d = StHalt;
                        endcase
                    end
                    OpLoad, OpStore: begin
                        state_d = StMem;
                    end
                    default: begin
                        state_d = StHalt;
                    end
                endcase
            end
            StMem: begin
                // Operands come straight from the regfile; nothing writes it until ack
                o_dmem_req   = 1'b1;
                o_dmem_we    = (opc == OpStore);
                o_dmem_addr  = rb_data;
                o_dmem_wdata = ra_data;
                if (i_dmem_ack) begin
                    if (opc == OpLoad) begin
                        rf_we    = 1'b1;
                        rf_wdata = i_dmem_rdata;
                    end
                    pc_d    = pc_inc;
                    state_d = StFetch;
                end
            end
            StHalt: begin
                o_halted = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef CPU_ISSUE_RETIRE_CNT_EN
    logic [31:0] retired_q;
    logic        retire;

    // Exec->Fetch is exactly a completed non-memory instruction
    assign retire = ((state_q == StExec) && (state_d == StFetch)) ||
                    ((state_q == StMem) && i_dmem_ack);

    // Retired-instruction counter, wraps at 2^32
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            retired_q <= 32'd0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign o_retired = retired_q;
`endif

endmodule

// File: doc/cpu_issue_unit.md
Name: cpu_issue_unit

Overview:
- Fetch/decode/register-file/writeback sequencer directly upstream of the ALU.
- Fetches 16-bit instructions over an instruction-memory handshake and decodes them.
- Drives the ALU operand/opcode inputs from a 4x16 register file and writes the ALU result back.
- Executes JUMP, LOADC, LOAD and STORE itself (LOAD/STORE through a data-memory handshake).

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NUM_REGS, 4, register-file depth; fixed by the 2-bit register fields.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- o_imem_req  out  1  instruction fetch request, held until ack
- o_imem_addr  out  16  fetch address (= PC)
- i_imem_ack  in  1  fetch complete; i_imem_data valid this cycle
- i_imem_data  in  16  instruction word
- o_dmem_req  out  1  data access request, held until ack
- o_dmem_we  out  1  1 = STORE, 0 = LOAD
- o_dmem_addr  out  16  data address
- o_dmem_wdata  out  16  store data
- i_dmem_ack  in  1  data access complete
- i_dmem_rdata  in  16  load data, valid with ack
- o_alu_opcode  out  4  IR[15:12]
- o_alu_extra  out  2  IR[11:10]
- o_alu_data1  out  16  first ALU operand
- o_alu_data2  out  16  second ALU operand
- o_alu_const  out  8  IR[7:0]
- i_alu_data  in  16  ALU result (combinational)
- o_pc  out  16  current PC
- o_halted  out  1  illegal opcode trapped

Behaviour:
- Instruction fields: opcode = IR[15:12], extra = IR[11:10], rA = IR[9:8], rB = IR[7:6], const = IR[7:0].
- Reset (async, i_rst_n = 0):
  - PC = RESET_PC; IR = 0; all registers = 0; state = IDLE.
  - All outputs 0, except o_pc = RESET_PC.
- IDLE: one cycle, then FETCH.
- FETCH:
  - o_imem_req = 1 and o_imem_addr = PC, both stable until i_imem_ack.
  - On ack: IR <= i_imem_data, go to EXEC. Ack in the first request cycle is legal.
- EXEC (exactly one cycle):
  - ALU inputs are driven only in EXEC; they are 0 in all other states.
  - ADD/SUB/AND/OR/SHIFT: data1 = R[rA], data2 = R[rB]; at the cycle end R[rA] <= i_alu_data, PC <= PC+1.
  - MOVE: data1 = R[rB]; R[rA] <= i_alu_data.
  - LOADC:
    - extra[0] = 0: R[rA] <= {8'h00, const}.
    - extra[0] = 1: R[rA] <= {const, R[rA][7:0]}.
  - JUMP:
    - extra 0: PC <= R[rB].
    - extra 1: PC <= PC + sext(const).
    - extra 2: if R[rA] == 0 then PC <= PC + sext(const), else PC+1.
    - extra 3: illegal.
  - LOAD/STORE: go to MEM. o_dmem_addr = R[rB]; o_dmem_wdata = R[rA].
  - UNDEF1..6 and illegal JUMP: go to HALT; PC is not advanced.
- MEM:
  - o_dmem_req = 1 until i_dmem_ack; o_dmem_addr, o_dmem_we and o_dmem_wdata are held stable.
  - On ack: for LOAD, R[rA] <= i_dmem_rdata. Then PC <= PC+1 and go to FETCH.
- HALT: o_halted = 1; absorbing state; exited only by reset.
- PC arithmetic is modulo 2^16: FFFF+1 wraps to 0000, and relative jumps wrap too.
- Latency: ALU/LOADC/JUMP instruction = fetch-ack cycle + 1. Memory instructions add the dmem wait plus 1.
- Reset asserted mid-fetch or mid-MEM: requests drop immediately; no register write occurs.
- Ack inputs arriving outside their matching request state are ignored.

Optional Feature:
- Macro: CPU_ISSUE_RETIRE_CNT_EN.
- Defined: adds output o_retired[31:0], reset 0, incremented once per completed instruction (EXEC non-memory/non-halting, or MEM ack). It wraps at 2^32 and does not count the halting instruction.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Opcode constants (ADD..UNDEF6) come from the shared opcodes header, also used by the ALU.
- State encodings and field bit positions are localparams in a shared cpu_defs header.
- Natural sub-module: cpu_regfile (4x16, two combinational reads, one synchronous write, async active-low clear).

Test Plan:
- Reset release with i_imem_ack tied high: o_imem_req rises on cycle 2 with o_imem_addr = 0000, then PC advances one step per two cycles.
- LOADC R0 low 0x34, LOADC R0 high 0x12 -> R0 = 1234. ADD R0, R0 with the ALU model -> R0 = 2468.
- LOAD R1 from [R2 = 0x0040] with ack delayed 3 cycles -> addr, req and we = 0 held 3 cycles; R1 = i_dmem_rdata; PC+1.
- JUMP extra 1, const 0xFE, at PC 0005 -> next fetch at 0003. Same jump at PC 0000 -> FFFE. JUMP extra 2 with R3 != 0 -> PC+1.
- Fetch opcode UNDEF1 -> o_halted = 1; no further o_imem_req; PC unchanged; i_rst_n pulse recovers to PC = RESET_PC.
- With CPU_ISSUE_RETIRE_CNT_EN: 5 instructions then an UNDEF -> o_retired = 5.
